// File: rtl/l1_inval_queue_pkg.sv
// Shared platform constants plus the invalidation queue's local types.
// marian_fpga_pkg carries the system-wide address and L1 geometry defaults.
package marian_fpga_pkg;
    localparam int unsigned AddrWidth   = 64;
    localparam int unsigned L1LineWidth = 16;
endpackage

package l1_inval_queue_pkg;
    typedef enum logic {
        Idle,
        Issue
    } inval_state_e;

    localparam logic [15:0] DedupCntMax = 16'hFFFF;
endpackage

// File: rtl/l1_inval_queue_fifo.sv
// Small FIFO with optional fall-through: an empty FIFO presents the incoming
// word on data_o in the same cycle, and a simultaneous pop bypasses storage.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    logic [ADDR_DEPTH-1:0]             rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_DEPTH:0]               cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_q;
    logic                              we;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        data_o  = mem_q[rd_q];
        empty_o = (cnt_q == '0);
        if (push_i && !full_o) begin
            we    = 1'b1;
            wr_d  = wr_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
        end
        if (pop_i && (cnt_q != '0)) begin
            rd_d  = rd_q + 1'b1;
            cnt_d = cnt_d - 1'b1;
        end
        // Bypass: the word never lands in storage when it is consumed at once.
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o  = data_i;
            empty_o = 1'b0;
            if (pop_i) begin
                we    = 1'b0;
                wr_d  = wr_q;
                rd_d  = rd_q;
                cnt_d = cnt_q;
            end
        end
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            we    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            mem_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (we) mem_q[wr_q] <= data_i;
        end
    end
endmodule

// File: rtl/l1_inval_queue.sv
// Queues line invalidations for the L1 D-cache, merges back-to-back repeats
// of the most recent line, and issues them one at a time with a req/ack pair.
module l1_inval_queue
    import l1_inval_queue_pkg::*;
#(
    parameter int unsigned AddrWidth   = marian_fpga_pkg::AddrWidth,
    parameter int unsigned L1LineWidth = marian_fpga_pkg::L1LineWidth,
    parameter int unsigned Depth       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] inval_addr_i,
    input  logic                 inval_valid_i,
    output logic                 inval_ready_o,
    output logic                 cache_inval_req_o,
    output logic [AddrWidth-1:0] cache_inval_addr_o,
    input  logic                 cache_inval_ack_i,
    output logic                 busy_o,
    output logic [15:0]          dedup_cnt_o
);
    localparam int unsigned UsageW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(L1LineWidth - 1);

    inval_state_e         state_q, state_d;
    logic                 req_q, req_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] last_line_q, last_line_d;
    logic [15:0]          dedup_q, dedup_d;

    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [UsageW-1:0]    fifo_usage;
    logic [AddrWidth-1:0] fifo_data;
    logic [AddrWidth-1:0] line;
    logic                 last_pending, dup, hs;

    assign line = inval_addr_i & LineMask;

    // Use stored occupancy, not fall-through empty_o, to avoid a loop through push.
    assign last_pending  = fifo_full || (fifo_usage != '0) || (state_q == Issue);
    assign dup           = en_i && last_pending && (line == last_line_q);
    assign inval_ready_o = !en_i || !fifo_full || dup;
    assign hs            = inval_valid_i && inval_ready_o;
    assign fifo_push     = hs && en_i && !dup;

    assign busy_o             = last_pending;
    assign cache_inval_req_o  = req_q;
    assign cache_inval_addr_o = addr_q;
    assign dedup_cnt_o        = dedup_q;

    fifo_v3 #(
        .FALL_THROUGH (1'b1),
        .DATA_WIDTH   (AddrWidth),
        .DEPTH        (Depth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (line),
        .push_i  (fifo_push),
        .data_o  (fifo_data),
        .pop_i   (fifo_pop)
    );

    always_comb begin
        last_line_d = fifo_push ? line : last_line_q;
        dedup_d     = dedup_q;
        if (hs && dup && (dedup_q != DedupCntMax)) dedup_d = dedup_q + 16'd1;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            Idle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_data;
                    req_d    = 1'b1;
                    state_d  = Issue;
                end
            end
            Issue: begin
                if (cache_inval_ack_i) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        addr_d   = fifo_data;
                    end else begin
                        req_d   = 1'b0;
                        state_d = Idle;
                    end
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            req_q       <= 1'b0;
            addr_q      <= '0;
            last_line_q <= '0;
            dedup_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            last_line_q <= last_line_d;
            dedup_q     <= dedup_d;
        end
    end
endmodule

// File: tb/tb_l1_inval_queue.sv
// Scoreboard bench for l1_inval_queue: expected lines queued on accept,
// compared against each acknowledged L1 request in order.
module tb_l1_inval_queue;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [63:0] inval_addr_i;
    logic        inval_valid_i;
    logic        inval_ready_o;
    logic        cache_inval_req_o;
    logic [63:0] cache_inval_addr_o;
    logic        cache_inval_ack_i;
    logic        busy_o;
    logic [15:0] dedup_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    l1_inval_queue #(.AddrWidth(64), .L1LineWidth(16), .Depth(4)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .en_i               (en_i),
        .inval_addr_i       (inval_addr_i),
        .inval_valid_i      (inval_valid_i),
        .inval_ready_o      (inval_ready_o),
        .cache_inval_req_o  (cache_inval_req_o),
        .cache_inval_addr_o (cache_inval_addr_o),
        .cache_inval_ack_i  (cache_inval_ack_i),
        .busy_o             (busy_o),
        .dedup_cnt_o        (dedup_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive(input logic [63:0] a, input bit expect_push);
        inval_valid_i = 1'b1;
        inval_addr_i  = a;
        if (expect_push) exp_q.push_back(a & ~64'hF);
    endtask

    // Every request the L1 acknowledges must be the next expected line.
    always @(negedge clk_i) begin
        if (rst_ni && cache_inval_req_o && cache_inval_ack_i) begin
            if (exp_q.size() == 0) chk("extra_req", 64'(exp_q.size()), 64'd1);
            else chk("issue_addr", cache_inval_addr_o, exp_q.pop_front());
        end
    end

    initial begin
        rst_ni = 1'b0; en_i = 1'b1; inval_addr_i = '0;
        inval_valid_i = 1'b0; cache_inval_ack_i = 1'b0;
        step(); step();
        chk("rst_req", 64'(cache_inval_req_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(inval_ready_o), 64'd1);
        chk("rst_cnt", 64'(dedup_cnt_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // single request: one-cycle latency, drop after ack
        drive(64'h1004, 1);
        #1 chk("s1_ready", 64'(inval_ready_o), 64'd1);
        step(); inval_valid_i = 1'b0;
        #1 chk("s1_req", 64'(cache_inval_req_o), 64'd1);
        chk("s1_addr", cache_inval_addr_o, 64'h1000);
        chk("s1_busy", 64'(busy_o), 64'd1);
        step(); step();
        cache_inval_ack_i = 1'b1;
        step(); cache_inval_ack_i = 1'b0;
        #1 chk("s1_req_done", 64'(cache_inval_req_o), 64'd0);
        chk("s1_busy_done", 64'(busy_o), 64'd0);

        // same line twice: merged
        drive(64'h1000, 1);
        step();
        drive(64'h100C, 0);
        #1 chk("s2_ready", 64'(inval_ready_o), 64'd1);
        step(); inval_valid_i = 1'b0;
        #1 chk("s2_cnt", 64'(dedup_cnt_o), 64'd1);
        chk("s2_addr", cache_inval_addr_o, 64'h1000);
        cache_inval_ack_i = 1'b1;
        step(); cache_inval_ack_i = 1'b0;
        #1 chk("s2_req_done", 64'(cache_inval_req_o), 64'd0);
        chk("s2_busy", 64'(busy_o), 64'd0);

        // fill to capacity, stall, duplicate while full, back-to-back drain
        for (int i = 0; i < 5; i++) begin
            drive(64'(i * 16), 1);
            #1 chk("s3_ready_fill", 64'(inval_ready_o), 64'd1);
            step();
        end
        drive(64'h50, 0);
        #1 chk("s3_ready_full", 64'(inval_ready_o), 64'd0);
        step();
        drive(64'h40, 0);
        #1 chk("s3_ready_dup", 64'(inval_ready_o), 64'd1);
        step(); inval_valid_i = 1'b0;
        #1 chk("s3_cnt", 64'(dedup_cnt_o), 64'd2);
        chk("s3_busy", 64'(busy_o), 64'd1);
        cache_inval_ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("s3_b2b_req", 64'(cache_inval_req_o), 64'd1);
            step();
        end
        cache_inval_ack_i = 1'b0;
        #1 chk("s3_req_done", 64'(cache_inval_req_o), 64'd0);
        chk("s3_busy_done", 64'(busy_o), 64'd0);
        chk("s3_drained", 64'(exp_q.size()), 64'd0);

        // same line after completion is a fresh request
        drive(64'h2000, 1);
        step(); inval_valid_i = 1'b0;
        cache_inval_ack_i = 1'b1;
        step(); cache_inval_ack_i = 1'b0;
        #1 chk("s4_busy", 64'(busy_o), 64'd0);
        drive(64'h2008, 1);
        step(); inval_valid_i = 1'b0;
        #1 chk("s4_req", 64'(cache_inval_req_o), 64'd1);
        chk("s4_addr", cache_inval_addr_o, 64'h2000);
        chk("s4_cnt", 64'(dedup_cnt_o), 64'd2);
        cache_inval_ack_i = 1'b1;
        step(); cache_inval_ack_i = 1'b0;

        // disabled: accept and drop
        en_i = 1'b0;
        drive(64'h3000, 0);
        #1 chk("s5_ready", 64'(inval_ready_o), 64'd1);
        step(); inval_valid_i = 1'b0; en_i = 1'b1;
        #1 chk("s5_req", 64'(cache_inval_req_o), 64'd0);
        chk("s5_busy", 64'(busy_o), 64'd0);
        chk("s5_cnt", 64'(dedup_cnt_o), 64'd2);

        // async reset mid-issue with entries queued
        for (int i = 0; i < 4; i++) begin
            drive(64'h4000 + 64'(i * 16), 1);
            step();
        end
        inval_valid_i = 1'b0;
        #1 chk("s6_busy_pre", 64'(busy_o), 64'd1);
        chk("s6_req_pre", 64'(cache_inval_req_o), 64'd1);
        rst_ni = 1'b0;
        #1 chk("s6_req_rst", 64'(cache_inval_req_o), 64'd0);
        chk("s6_busy_rst", 64'(busy_o), 64'd0);
        chk("s6_cnt_rst", 64'(dedup_cnt_o), 64'd0);
        chk("s6_ready_rst", 64'(inval_ready_o), 64'd1);
        exp_q.delete();
        step(); step();
        rst_ni = 1'b1;
        cache_inval_ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("s6_no_req", 64'(cache_inval_req_o), 64'd0);
            step();
        end
        cache_inval_ack_i = 1'b0;
        chk("s6_busy_post", 64'(busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
